// File: rtl/multi_freq_divider.sv
// multi_freq_divider: CHANNELS independent programmable clock-enable dividers.
// Each channel produces a registered divided waveform (clk_out) and a one-cycle
// tick at every period start. New period/high values arrive on a valid/ready
// port. They are held pending and become active only at that channel's next
// period boundary, so a period in progress is never cut short or stretched.
// Optional feature macro: FREQDIV_SYNC_EN adds sync_in, which restarts every
// enabled channel on the same edge.
module multi_freq_divider #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 5208,
  parameter int DEFAULT_HIGH   = 2604
) (
  input  logic                         clk,
  input  logic                         Reset,
`ifdef FREQDIV_SYNC_EN
  input  logic                         sync_in,
`endif
  input  logic [CHANNELS-1:0]          enable,
  input  logic                         cfg_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [WIDTH-1:0]             cfg_period,
  input  logic [WIDTH-1:0]             cfg_high,
  output logic                         cfg_ready,
  output logic [CHANNELS-1:0]          clk_out,
  output logic [CHANNELS-1:0]          tick
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] w_pend;
  logic [CHANNELS-1:0] w_accept;
  logic                w_ready;
  logic [WIDTH-1:0]    w_san_period;
  logic [WIDTH-1:0]    w_san_high;

  // Ready reflects the addressed channel's pending flag; unknown channels
  // always look ready and their writes are simply not latched anywhere.
  always_comb begin
    w_ready  = 1'b1;
    w_accept = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) begin
        w_ready     = ~w_pend[i];
        w_accept[i] = cfg_valid & ~w_pend[i];
      end
    end
  end

  assign cfg_ready = w_ready;

  // Clamp requested values so every active config is a legal waveform:
  // period of at least 2 and high time strictly below the period.
  always_comb begin
    w_san_period = (cfg_period < WIDTH'(2)) ? WIDTH'(2) : cfg_period;
    w_san_high   = (cfg_high >= w_san_period) ? (w_san_period - WIDTH'(1)) : cfg_high;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_sync;
    logic             w_apply;
    logic [WIDTH-1:0] w_period_n;
    logic [WIDTH-1:0] w_high_n;
    logic [WIDTH-1:0] w_cnt_n;

    // Next-state for one channel. A disabled channel parks its counter on the
    // last count so the first enabled edge wraps and opens a full period.
    always_comb begin
`ifdef FREQDIV_SYNC_EN
      w_sync = sync_in & enable[g];
`else
      w_sync = 1'b0;
`endif
      w_wrap     = (r_cnt >= (r_period - WIDTH'(1)));
      w_apply    = r_pend & (~enable[g] | w_wrap | w_sync);
      w_period_n = w_apply ? r_pend_period : r_period;
      w_high_n   = w_apply ? r_pend_high   : r_high;
      if (!enable[g]) begin
        w_cnt_n = w_period_n - WIDTH'(1);
      end else if (w_sync || w_wrap) begin
        w_cnt_n = '0;
      end else begin
        w_cnt_n = r_cnt + WIDTH'(1);
      end
    end

    // Channel state: counter, active/pending config and registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
        r_cnt         <= WIDTH'(DEFAULT_PERIOD - 1);
        r_period      <= WIDTH'(DEFAULT_PERIOD);
        r_high        <= WIDTH'(DEFAULT_HIGH);
        r_pend_period <= '0;
        r_pend_high   <= '0;
        r_pend        <= 1'b0;
        r_clk         <= 1'b0;
        r_tick        <= 1'b0;
      end else begin
        r_cnt    <= w_cnt_n;
        r_period <= w_period_n;
        r_high   <= w_high_n;
        r_clk    <= enable[g] & (w_cnt_n < w_high_n);
        r_tick   <= enable[g] & (w_wrap | w_sync);
        // Accept and apply never coincide: accept needs pending clear,
        // apply needs it set.
        if (w_accept[g]) begin
          r_pend        <= 1'b1;
          r_pend_period <= w_san_period;
          r_pend_high   <= w_san_high;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_pend[g]  = r_pend;
    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_multi_freq_divider.sv
module tb_multi_freq_divider;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int DP = 5208;
  localparam int DH = 2604;

  logic          clk = 1'b0;
  logic          Reset;
  logic [CH-1:0] enable;
  logic          cfg_valid;
  logic [0:0]    cfg_chan;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_high;
  logic          cfg_ready;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
`ifdef FREQDIV_SYNC_EN
  logic          sync_in = 1'b0;
`endif

  multi_freq_divider #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(DP), .DEFAULT_HIGH(DH)
  ) dut (
    .clk(clk), .Reset(Reset),
`ifdef FREQDIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .enable(enable), .cfg_valid(cfg_valid), .cfg_chan(cfg_chan),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ready(cfg_ready),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel tracks its position within the current
  // period (or "idle" when not running), active period/high, and at most one
  // queued config. Outputs follow from position: tick at position 0, high
  // while position < high time.
  int          m_pos [CH];
  int          m_per [CH];
  int          m_hi  [CH];
  int          m_qper[CH];
  int          m_qhi [CH];
  bit          m_run [CH];
  bit          m_q   [CH];
  bit [CH-1:0] e_clk;
  bit [CH-1:0] e_tick;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 0; m_per[i] = DP; m_hi[i] = DH;
      m_run[i] = 0; m_q[i] = 0; m_qper[i] = 0; m_qhi[i] = 0;
    end
    e_clk  = '0;
    e_tick = '0;
  endfunction

  always @(posedge clk) begin
    if (!Reset) begin
      model_reset();
    end else begin
      int acc;
      int c;
      c   = int'(cfg_chan);
      acc = -1;
      if (cfg_valid && c < CH && !m_q[c]) acc = c;
      for (int i = 0; i < CH; i++) begin
        if (!enable[i]) begin
          if (m_q[i]) begin m_per[i] = m_qper[i]; m_hi[i] = m_qhi[i]; m_q[i] = 0; end
          m_run[i] = 0;
          e_clk[i] = 0; e_tick[i] = 0;
        end else begin
          if (!m_run[i] || m_pos[i] == m_per[i] - 1) begin
            if (m_q[i]) begin m_per[i] = m_qper[i]; m_hi[i] = m_qhi[i]; m_q[i] = 0; end
            m_pos[i]  = 0;
            e_tick[i] = 1;
          end else begin
            m_pos[i]  = m_pos[i] + 1;
            e_tick[i] = 0;
          end
          m_run[i] = 1;
          e_clk[i] = (m_pos[i] < m_hi[i]);
        end
      end
      if (acc >= 0) begin
        m_q[acc]    = 1;
        m_qper[acc] = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
        m_qhi[acc]  = (int'(cfg_high) >= m_qper[acc]) ? m_qper[acc] - 1 : int'(cfg_high);
      end
    end
    #1;
    check("clk_out", int'(clk_out), int'(e_clk));
    check("tick", int'(tick), int'(e_tick));
    check("cfg_ready", int'(cfg_ready), (int'(cfg_chan) >= CH) ? 1 : int'(!m_q[int'(cfg_chan)]));
  end

  // Count ticks and high cycles of one channel over n edges.
  task automatic window(input int ch, input int n, output int t, output int h);
    t = 0; h = 0;
    repeat (n) begin
      @(posedge clk); #2;
      t += int'(tick[ch]);
      h += int'(clk_out[ch]);
    end
  endtask

  // Present a config and hold it until accepted (bounded).
  task automatic send(input int ch, input int p, input int h);
    bit done;
    done = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_chan = 1'(ch); cfg_period = W'(p); cfg_high = W'(h);
    for (int k = 0; k < 12000 && !done; k++) begin
      #1;
      if (cfg_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Wait (bounded) until the channel's queued config has been applied.
  task automatic wait_ready(input int ch);
    bit done;
    done = 0;
    @(negedge clk);
    cfg_chan = 1'(ch);
    for (int k = 0; k < 12000 && !done; k++) begin
      #1;
      if (cfg_ready) done = 1;
      else @(negedge clk);
    end
    if (!done) check("apply_timeout", 0, 1);
  endtask

  initial begin
    int t, h;
    Reset = 1'b0; enable = '0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_period = '0; cfg_high = '0;
    model_reset();
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_ready", int'(cfg_ready), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); Reset = 1'b1;

    // Defaults on channel 0: two full 5208-cycle periods.
    @(negedge clk); enable = 2'b01;
    window(0, 2 * DP, t, h);
    check("default_ticks", t, 2);
    check("default_highs", h, 2 * DH);

    // Reconfigure running channel 1 to 10/3; old period must finish first.
    @(negedge clk); enable = 2'b11;
    repeat (100) @(posedge clk);
    send(1, 10, 3);
    wait_ready(1);
    window(1, 100, t, h);
    check("ch1_ticks", t, 10);
    check("ch1_highs", h, 30);

    // Second write to a pending channel stalls until the first applies.
    send(0, 20, 5);
    #1;
    check("stall_ready", int'(cfg_ready), 0);
    send(0, 6, 2);
    #1;
    check("second_pending", int'(cfg_ready), 0);

    // Sanitising: 1/5 becomes 2/1; high=0 keeps clk_out low.
    send(0, 1, 5);
    wait_ready(0);
    window(0, 20, t, h);
    check("min_period_ticks", t, 10);
    check("min_period_highs", h, 10);
    send(1, 4, 0);
    wait_ready(1);
    window(1, 20, t, h);
    check("zero_high_ticks", t, 5);
    check("zero_high_highs", h, 0);

    // Disable mid-period, then re-enable.
    @(negedge clk); enable[0] = 1'b0;
    @(posedge clk); #2;
    check("disabled_clk", int'(clk_out[0]), 0);
    check("disabled_tick", int'(tick[0]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); enable[0] = 1'b1;
    @(posedge clk); #2;
    check("reenable_tick", int'(tick[0]), 1);
    check("reenable_clk", int'(clk_out[0]), 1);

    // Reset mid-operation with a config queued on channel 1.
    send(1, 7, 3);
    repeat (2) @(posedge clk);
    @(negedge clk); Reset = 1'b0; cfg_chan = 1'b1;
    #1;
    check("midreset_clk", int'(clk_out), 0);
    check("midreset_tick", int'(tick), 0);
    check("midreset_ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk); Reset = 1'b1;

    // Randomised traffic, checked every cycle by the model.
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) enable = CH'($urandom);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_chan   = 1'($urandom_range(0, CH - 1));
      cfg_period = W'($urandom_range(0, 12));
      cfg_high   = W'($urandom_range(0, 14));
    end
    @(negedge clk); cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
